// File: rtl/starflux_pkg.sv
// Shared definitions for the Starflux game-flow logic.
//   state_e : game sequencer FSM states, 3-bit encoding
//   CLK_HZ  : system clock frequency the frame divider is derived from
package starflux_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIP  = 3'd3,
    S_GRID  = 3'd4,
    S_DRAW  = 3'd5,
    S_OVER  = 3'd6
  } state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick divider. Counts 0..TICK_DIV-1 and flags the wrap cycle.
//   clk   : system clock
//   reset : async active-low reset
//   clear : synchronous restart of the count at 0
//   tick  : high for the one cycle in which the counter wraps
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (clear || tick)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/game_sequencer.sv
// Starflux top-level game-flow sequencer. Derives a frame tick, pulses the
// logic datapath enables once per frame, hands the frame to the VGA drawer
// and waits for its done, and detects game over from ship health.
// Optional feature: GAME_SEQ_PAUSE_EN -- pause freezes the game while idle
// between frames (ticks in S_WAIT are swallowed); without it pause is ignored.
//   clk, reset       : 50 MHz clock, async active-low reset
//   start            : level start/restart request
//   ship_health[3:0] : user ship health, sampled on a tick in S_WAIT
//   draw_done        : drawer completion pulse, honoured only in S_DRAW
//   pause            : level pause request (optional feature)
//   startGameEn / shipUpdateEn / gridUpdateEn : one-cycle datapath enables
//   draw_req         : held while waiting for draw_done
//   gameover_signal  : pulse on entry to S_OVER; game_over : level in S_OVER
//   frame_overrun    : sticky, a tick arrived outside S_WAIT
//   frame_count[7:0] : completed frames since start, wrapping
module game_sequencer
  import starflux_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int GRID_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ship_health,
  input  logic       draw_done,
  input  logic       pause,
  output logic       startGameEn,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       draw_req,
  output logic       gameover_signal,
  output logic       game_over,
  output logic       frame_overrun,
  output logic [7:0] frame_count
);

  localparam int            GW        = $clog2(GRID_DIV + 1);
  localparam logic [GW-1:0] GRID_LAST = GW'(GRID_DIV - 1);

  state_e        state, state_nxt;
  logic          tick;
  logic          paused;
  logic          grid_last;
  logic [GW-1:0] grid_cnt;
  logic          over_q;   // was in S_OVER last cycle; edge-detects entry

`ifdef GAME_SEQ_PAUSE_EN
  assign paused = pause;
`else
  logic pause_unused;
  assign pause_unused = pause;
  assign paused       = 1'b0;
`endif

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state == S_START),
    .tick  (tick)
  );

  assign grid_last = (grid_cnt == GRID_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      // Health is only looked at here, so a mid-frame zero finishes the frame.
      S_WAIT:  if (tick && !paused)
                 state_nxt = (ship_health == 4'd0) ? S_OVER : S_SHIP;
      S_SHIP:  state_nxt = grid_last ? S_GRID : S_DRAW;
      S_GRID:  state_nxt = S_DRAW;
      S_DRAW:  if (draw_done) state_nxt = S_WAIT;
      S_OVER:  if (start) state_nxt = S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      grid_cnt      <= '0;
      frame_count   <= 8'd0;
      frame_overrun <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state  <= state_nxt;
      over_q <= (state == S_OVER);
      case (state)
        S_START: begin
          grid_cnt    <= '0;
          frame_count <= 8'd0;
        end
        S_SHIP:  grid_cnt <= grid_last ? '0 : grid_cnt + 1'b1;
        S_DRAW:  if (draw_done) frame_count <= frame_count + 8'd1;
        default: ;
      endcase
      // Ticks are never queued: any tick the FSM cannot consume is flagged.
      // A paused S_WAIT still counts as consuming it.
      if (state == S_START)
        frame_overrun <= 1'b0;
      else if (tick && state != S_WAIT)
        frame_overrun <= 1'b1;
    end
  end

  // Moore decode keeps the enables mutually exclusive and lets async reset
  // drop every output (including draw_req) immediately.
  assign startGameEn     = (state == S_START);
  assign shipUpdateEn    = (state == S_SHIP);
  assign gridUpdateEn    = (state == S_GRID);
  assign draw_req        = (state == S_DRAW);
  assign game_over       = (state == S_OVER);
  assign gameover_signal = (state == S_OVER) && !over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer (TICK_DIV=4, GRID_DIV=2).
module tb_game_sequencer;

  localparam int TICK_DIV = 4;
  localparam int GRID_DIV = 2;
`ifdef GAME_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ship_health = 4'd4;
  logic       draw_done = 1'b0;
  logic       pause = 1'b0;
  logic       startGameEn, shipUpdateEn, gridUpdateEn, draw_req;
  logic       gameover_signal, game_over, frame_overrun;
  logic [7:0] frame_count;

  int n_chk = 0, n_pass = 0;
  int n_ship = 0, n_grid = 0, n_gos = 0;

  always #5 clk = ~clk;

  game_sequencer #(.TICK_DIV(TICK_DIV), .GRID_DIV(GRID_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .ship_health(ship_health),
    .draw_done(draw_done), .pause(pause), .startGameEn(startGameEn),
    .shipUpdateEn(shipUpdateEn), .gridUpdateEn(gridUpdateEn),
    .draw_req(draw_req), .gameover_signal(gameover_signal),
    .game_over(game_over), .frame_overrun(frame_overrun),
    .frame_count(frame_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_START = 1, M_WAIT = 2, M_SHIP = 3,
                 M_GRID = 4, M_DRAW = 5, M_OVER = 6;
  int m_st = M_IDLE, m_nst = M_IDLE;
  int m_since = 0;     // cycles since reset or last game start
  int m_grid = 0, m_fc = 0;
  bit m_ovr = 0, m_prev_over = 0, m_tk = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = M_IDLE; m_since = 0; m_grid = 0; m_fc = 0;
      m_ovr = 0; m_prev_over = 0;
    end else begin
      m_tk  = (m_since % TICK_DIV) == TICK_DIV - 1;
      m_nst = m_st;
      case (m_st)
        M_IDLE:  if (start) m_nst = M_START;
        M_START: begin m_grid = 0; m_fc = 0; m_nst = M_WAIT; end
        M_WAIT:  if (m_tk && !(PAUSE_EN && pause))
                   m_nst = (ship_health == 0) ? M_OVER : M_SHIP;
        M_SHIP:  if (m_grid == GRID_DIV - 1) begin m_grid = 0; m_nst = M_GRID; end
                 else begin m_grid++; m_nst = M_DRAW; end
        M_GRID:  m_nst = M_DRAW;
        M_DRAW:  if (draw_done) begin m_fc = (m_fc + 1) % 256; m_nst = M_WAIT; end
        M_OVER:  if (start) m_nst = M_START;
        default: m_nst = M_IDLE;
      endcase
      if (m_st == M_START) m_ovr = 0;
      else if (m_tk && m_st != M_WAIT) m_ovr = 1;
      m_since     = (m_st == M_START) ? 0 : m_since + 1;
      m_prev_over = (m_st == M_OVER);
      m_st        = m_nst;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("startGameEn",     startGameEn,     m_st == M_START);
    chk("shipUpdateEn",    shipUpdateEn,    m_st == M_SHIP);
    chk("gridUpdateEn",    gridUpdateEn,    m_st == M_GRID);
    chk("draw_req",        draw_req,        m_st == M_DRAW);
    chk("game_over",       game_over,       m_st == M_OVER);
    chk("gameover_signal", gameover_signal, (m_st == M_OVER) && !m_prev_over);
    chk("frame_overrun",   frame_overrun,   m_ovr);
    chk("frame_count",     frame_count,     m_fc);
    chk("enables_exclusive", (startGameEn + shipUpdateEn + gridUpdateEn) <= 2'd1, 1);
    if (shipUpdateEn)    n_ship++;
    if (gridUpdateEn)    n_grid++;
    if (gameover_signal) n_gos++;
  end

  // ---------------- drawer model ----------------
  int drw_delay = 1, drw_cnt = 0;
  bit drw_hold = 0, drw_spur = 0;

  always @(posedge clk) begin
    #1;
    if (!draw_req) begin
      drw_cnt   = 0;
      draw_done = drw_spur && ($urandom_range(0, 7) == 0);
    end else if (drw_hold) begin
      draw_done = 1'b0;
    end else begin
      drw_cnt++;
      draw_done = (drw_cnt >= drw_delay);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    int fc0;
    // 1: reset, then a single start pulse
    @(negedge clk);
    chk("reset_outputs", {startGameEn, shipUpdateEn, gridUpdateEn, draw_req,
                          gameover_signal, game_over, frame_overrun, frame_count}, 0);
    cyc(); reset = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("start_pulse", startGameEn, 1);
    chk("start_fc0", frame_count, 0);
    @(negedge clk);
    chk("start_one_cycle", startGameEn, 0);
    chk("start_no_overrun", frame_overrun, 0);

    // 2: four frames with healthy ship
    #1; n_ship = 0; n_grid = 0;
    for (int i = 0; i < 60 && frame_count != 8'd4; i++) @(negedge clk);
    #1;
    chk("four_frames", frame_count, 4);
    chk("four_ship_en", n_ship, 4);
    chk("two_grid_en", n_grid, 2);
    chk("four_no_overrun", frame_overrun, 0);

    // 3: drawer stalls
    drw_hold = 1;
    for (int i = 0; i < 20 && !draw_req; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("stall_draw_req", draw_req, 1);
    chk("stall_overrun", frame_overrun, 1);
    fc0 = frame_count;
    drw_hold = 0;
    for (int i = 0; i < 10 && draw_req; i++) @(negedge clk);
    chk("stall_fc_inc", frame_count, fc0 + 1);

    // 4: health drops mid-draw
    drw_hold = 1;
    for (int i = 0; i < 20 && !draw_req; i++) @(negedge clk);
    fc0 = frame_count;
    ship_health = 4'd0;
    #1; n_ship = 0; n_gos = 0;
    drw_hold = 0;
    for (int i = 0; i < 30 && !game_over; i++) @(negedge clk);
    #1;
    chk("over_reached", game_over, 1);
    chk("over_frame_done", frame_count, fc0 + 1);
    chk("over_no_ship", n_ship, 0);
    chk("over_pulse", n_gos, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("over_holds", game_over, 1);
    chk("over_pulse_once", n_gos, 1);
    chk("over_still_no_ship", n_ship, 0);

    // 5: restart from S_OVER
    cyc(); ship_health = 4'd4; start = 1'b1;
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("restart_pulse", startGameEn, 1);
    chk("restart_not_over", game_over, 0);
    @(negedge clk);
    chk("restart_overrun_clr", frame_overrun, 0);
    chk("restart_fc0", frame_count, 0);

    // 6: async reset during a draw
    drw_hold = 1;
    for (int i = 0; i < 30 && !draw_req; i++) @(negedge clk);
    chk("rst_in_draw", draw_req, 1);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", {startGameEn, shipUpdateEn, gridUpdateEn, draw_req,
                                   gameover_signal, game_over, frame_overrun, frame_count}, 0);
    cyc(); reset = 1'b1; drw_hold = 0;
    repeat (6) cyc();
    chk("idle_after_reset", startGameEn | draw_req | shipUpdateEn, 0);

    if (PAUSE_EN) begin
      start = 1'b1; cyc(); start = 1'b0; cyc();
      pause = 1'b1; #1 n_ship = 0;
      repeat (14) @(negedge clk);
      #1;
      chk("pause_no_ship", n_ship, 0);
      chk("pause_no_overrun", frame_overrun, 0);
      cyc(); pause = 1'b0;
    end

    // random phase
    drw_spur = 1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 999) == 0) reset = 1'b0;
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0)
        ship_health = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) drw_delay = $urandom_range(1, 5);
      if ($urandom_range(0, 59) == 0) drw_hold = ~drw_hold;
    end
    reset = 1'b1; drw_hold = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
